// File: rtl/lifn_pkg.sv
// Shared definitions for the neuron spike interface blocks.
// Holds the state encodings for the spike decoder FSMs and the default
// widths used when a decoder is instantiated without overriding them.
package lifn_pkg;

  localparam int DEFAULT_COUNT_W = 8;
  localparam int DEFAULT_ISI_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } win_state_t;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    TIMING     = 1'b1
  } isi_state_t;

endpackage

// File: rtl/spike_isi_timer.sv
// Inter-spike interval timer.
// Measures the number of clock cycles between consecutive spike events and
// presents the result with a one-cycle valid pulse.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        enable; low returns the timer to WAIT_FIRST and clears the counter
//   evt       one-cycle spike event (already edge detected)
//   isi       last captured interval, saturated at 2^ISI_W-1
//   isi_valid one-cycle pulse when isi updates
//   isi_ovf   the captured interval reached the counter maximum
module spike_isi_timer
  import lifn_pkg::*;
#(
  parameter int ISI_W = DEFAULT_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             evt,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic             isi_ovf
);

  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_ONE  = ISI_W'(1);
  localparam logic [ISI_W-1:0] ISI_ZERO = '0;

  isi_state_t       state_q, state_d;
  logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             isi_valid_q, isi_valid_d;
  logic             isi_ovf_q, isi_ovf_d;
  logic             cnt_at_max;

  assign cnt_at_max = (isi_cnt_q == ISI_MAX);

  // Next-state logic for the interval FSM, counter and capture registers.
  always_comb begin
    state_d     = state_q;
    isi_cnt_d   = isi_cnt_q;
    isi_d       = isi_q;
    isi_ovf_d   = isi_ovf_q;
    isi_valid_d = 1'b0;
    if (!en) begin
      state_d   = WAIT_FIRST;
      isi_cnt_d = ISI_ZERO;
    end else begin
      case (state_q)
        WAIT_FIRST: begin
          if (evt) begin
            // The cycle after the first event already counts as 1.
            state_d   = TIMING;
            isi_cnt_d = ISI_ONE;
          end else begin
            isi_cnt_d = ISI_ZERO;
          end
        end
        TIMING: begin
          if (evt) begin
            isi_d       = isi_cnt_q;
            isi_ovf_d   = cnt_at_max;
            isi_valid_d = 1'b1;
            isi_cnt_d   = ISI_ONE;
          end else if (!cnt_at_max) begin
            isi_cnt_d = isi_cnt_q + ISI_ONE;
          end else begin
            isi_cnt_d = ISI_MAX;
          end
        end
        default: begin
          state_d   = WAIT_FIRST;
          isi_cnt_d = ISI_ZERO;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_FIRST;
      isi_cnt_q   <= ISI_ZERO;
      isi_q       <= ISI_ZERO;
      isi_valid_q <= 1'b0;
      isi_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      isi_cnt_q   <= isi_cnt_d;
      isi_q       <= isi_d;
      isi_valid_q <= isi_valid_d;
      isi_ovf_q   <= isi_ovf_d;
    end
  end

  assign isi       = isi_q;
  assign isi_valid = isi_valid_q;
  assign isi_ovf   = isi_ovf_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train decoder: converts a 1-bit spike line into a per-window spike
// count (rate) and an inter-spike interval (isi).
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         decoder enable; low forces both FSMs idle
//   spike      spike line; an event is a 0->1 transition
//   window_len window length in cycles, sampled at each window start (0 -> 1)
//   rate       events counted in the last completed window
//   rate_valid one-cycle pulse when rate updates
//   rate_sat   the window that produced rate saturated the count
//   isi        cycles between the last two events
//   isi_valid  one-cycle pulse when isi updates
//   isi_ovf    the interval that produced isi reached the counter maximum
module spike_rate_decoder
  import lifn_pkg::*;
#(
  parameter int COUNT_W = DEFAULT_COUNT_W,
  parameter int ISI_W   = DEFAULT_ISI_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               spike,
  input  logic [7:0]         window_len,
  output logic [COUNT_W-1:0] rate,
  output logic               rate_valid,
  output logic               rate_sat,
  output logic [ISI_W-1:0]   isi,
  output logic               isi_valid,
  output logic               isi_ovf
);

  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ZERO = '0;

  logic               spike_q;
  logic               evt;
  win_state_t         state_q, state_d;
  logic [7:0]         win_left_q, win_left_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [COUNT_W-1:0] rate_q, rate_d;
  logic               rate_valid_q, rate_valid_d;
  logic               rate_sat_q, rate_sat_d;
  logic [7:0]         win_len_eff;
  logic               cnt_at_max;
  logic [COUNT_W-1:0] cnt_inc;

  assign evt         = spike & ~spike_q;
  assign win_len_eff = (window_len == 8'd0) ? 8'd1 : window_len;
  assign cnt_at_max  = (cnt_q == CNT_MAX);
  assign cnt_inc     = cnt_at_max ? CNT_MAX : (cnt_q + CNT_ONE);

  // Edge-detect delay; keeps tracking the line even while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike;
    end
  end

  // Next-state logic for the window FSM, event counter and rate outputs.
  always_comb begin
    state_d      = state_q;
    win_left_d   = win_left_q;
    cnt_d        = cnt_q;
    sat_d        = sat_q;
    rate_d       = rate_q;
    rate_sat_d   = rate_sat_q;
    rate_valid_d = 1'b0;
    if (!en) begin
      state_d    = IDLE;
      win_left_d = 8'd0;
      cnt_d      = CNT_ZERO;
      sat_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = COUNT;
          win_left_d = win_len_eff;
          cnt_d      = CNT_ZERO;
          sat_d      = 1'b0;
        end
        COUNT: begin
          if (win_left_q == 8'd1) begin
            // Last window cycle: its event still belongs to this window, and
            // the next window starts immediately with no gap.
            rate_d       = evt ? cnt_inc : cnt_q;
            rate_sat_d   = sat_q | (evt & cnt_at_max);
            rate_valid_d = 1'b1;
            win_left_d   = win_len_eff;
            cnt_d        = CNT_ZERO;
            sat_d        = 1'b0;
          end else begin
            win_left_d = win_left_q - 8'd1;
            if (evt) begin
              cnt_d = cnt_inc;
              sat_d = sat_q | cnt_at_max;
            end else begin
              cnt_d = cnt_q;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          win_left_d = 8'd0;
          cnt_d      = CNT_ZERO;
          sat_d      = 1'b0;
        end
      endcase
    end
  end

  // Window FSM state and rate output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      win_left_q   <= 8'd0;
      cnt_q        <= CNT_ZERO;
      sat_q        <= 1'b0;
      rate_q       <= CNT_ZERO;
      rate_valid_q <= 1'b0;
      rate_sat_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_left_q   <= win_left_d;
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      rate_sat_q   <= rate_sat_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign rate_sat   = rate_sat_q;

  spike_isi_timer #(
    .ISI_W(ISI_W)
  ) u_isi_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .evt      (evt),
    .isi      (isi),
    .isi_valid(isi_valid),
    .isi_ovf  (isi_ovf)
  );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: two instances (8/8 and 2/4 bit widths)
// share one stimulus stream; a timestamp-based reference model predicts
// every output on every cycle, plus directed checks for the key scenarios.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       spike;
  logic [7:0] window_len;

  logic [7:0] rate0;
  logic       rate_valid0, rate_sat0;
  logic [7:0] isi0;
  logic       isi_valid0, isi_ovf0;
  logic [1:0] rate1;
  logic       rate_valid1, rate_sat1;
  logic [3:0] isi1;
  logic       isi_valid1, isi_ovf1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.COUNT_W(8), .ISI_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .spike(spike), .window_len(window_len),
    .rate(rate0), .rate_valid(rate_valid0), .rate_sat(rate_sat0),
    .isi(isi0), .isi_valid(isi_valid0), .isi_ovf(isi_ovf0)
  );

  spike_rate_decoder #(.COUNT_W(2), .ISI_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .spike(spike), .window_len(window_len),
    .rate(rate1), .rate_valid(rate_valid1), .rate_sat(rate_sat1),
    .isi(isi1), .isi_valid(isi_valid1), .isi_ovf(isi_ovf1)
  );

  // Single comparison point: counts the check and reports any mismatch.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: windows and intervals tracked as absolute cycle stamps.
  int  cmax[2] = '{255, 3};
  int  imax[2] = '{255, 15};
  int  cyc = 0;
  bit  armed = 1'b0;
  bit  sprev = 1'b0;
  bit  win_act[2];
  int  win_end[2];
  int  wcnt[2];
  bit  isi_act[2];
  int  t_last[2];
  int  e_rate[2], e_rsat[2], e_rval[2], e_isi[2], e_iovf[2], e_ival[2];

  task automatic model_step(input logic r, input logic e, input logic s, input logic [7:0] w);
    bit evt;
    int n;
    int d;
    evt = s && !sprev;
    n = (w == 8'd0) ? 1 : int'(w);
    if (r) begin
      sprev = 1'b0;
      for (int m = 0; m < 2; m++) begin
        win_act[m] = 0; wcnt[m] = 0; isi_act[m] = 0;
        e_rate[m] = 0; e_rsat[m] = 0; e_rval[m] = 0;
        e_isi[m] = 0; e_iovf[m] = 0; e_ival[m] = 0;
      end
    end else begin
      sprev = s;
      for (int m = 0; m < 2; m++) begin
        e_rval[m] = 0;
        e_ival[m] = 0;
        if (!e) begin
          win_act[m] = 0;
          isi_act[m] = 0;
        end else begin
          // Window covering cycles (start .. win_end]; first counted cycle is the next one.
          if (!win_act[m]) begin
            win_act[m] = 1;
            win_end[m] = cyc + n;
            wcnt[m] = 0;
          end else begin
            if (evt) wcnt[m]++;
            if (cyc == win_end[m]) begin
              e_rate[m] = (wcnt[m] > cmax[m]) ? cmax[m] : wcnt[m];
              e_rsat[m] = (wcnt[m] > cmax[m]) ? 1 : 0;
              e_rval[m] = 1;
              wcnt[m] = 0;
              win_end[m] = cyc + n;
            end
          end
          if (evt) begin
            if (isi_act[m]) begin
              d = cyc - t_last[m];
              e_isi[m] = (d > imax[m]) ? imax[m] : d;
              e_iovf[m] = (d >= imax[m]) ? 1 : 0;
              e_ival[m] = 1;
            end
            isi_act[m] = 1;
            t_last[m] = cyc;
          end
        end
      end
    end
    cyc++;
  endtask

  // One clock cycle: apply inputs, compare outputs mid-cycle, advance the model.
  task automatic drive(input logic r, input logic e, input logic s, input logic [7:0] w);
    @(posedge clk);
    #1;
    rst = r; en = e; spike = s; window_len = w;
    @(negedge clk);
    if (armed) begin
      check("rate0", rate0, e_rate[0]);
      check("rate_valid0", rate_valid0, e_rval[0]);
      check("rate_sat0", rate_sat0, e_rsat[0]);
      check("isi0", isi0, e_isi[0]);
      check("isi_valid0", isi_valid0, e_ival[0]);
      check("isi_ovf0", isi_ovf0, e_iovf[0]);
      check("rate1", rate1, e_rate[1]);
      check("rate_valid1", rate_valid1, e_rval[1]);
      check("rate_sat1", rate_sat1, e_rsat[1]);
      check("isi1", isi1, e_isi[1]);
      check("isi_valid1", isi_valid1, e_ival[1]);
      check("isi_ovf1", isi_ovf1, e_iovf[1]);
    end
    model_step(r, e, s, w);
    armed = 1'b1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  logic       en_r;
  logic       sp_r;
  logic [7:0] wl_r;
  int         mode, seg_len, per;

  initial begin
    rst = 1'b1; en = 1'b0; spike = 1'b0; window_len = 8'd0;
    do_reset(3);
    drive(1'b0, 1'b0, 1'b0, 8'd10);
    check("reset_rate", rate0, 0);
    check("reset_isi", isi0, 0);

    // Pulse every 3 cycles from the first counted cycle, 10-cycle windows.
    drive(1'b0, 1'b1, 1'b0, 8'd10);
    for (int k = 1; k <= 40; k++) begin
      drive(1'b0, 1'b1, ((k - 1) % 3) == 0, 8'd10);
      if (k == 11) begin
        check("tp1_rate", rate0, 4);
        check("tp1_rate_valid", rate_valid0, 1);
      end
    end

    // Line held high 20 cycles in a 50-cycle window counts once.
    do_reset(2);
    drive(1'b0, 1'b1, 1'b0, 8'd50);
    for (int k = 1; k <= 60; k++) begin
      drive(1'b0, 1'b1, k <= 20, 8'd50);
      if (k == 51) begin
        check("held_rate", rate0, 1);
        check("held_rate_valid", rate_valid0, 1);
      end
    end

    // Events at relative cycles 0, 7, 300.
    do_reset(2);
    drive(1'b0, 1'b1, 1'b0, 8'd10);
    for (int k = 1; k <= 310; k++) begin
      drive(1'b0, 1'b1, (k == 1) || (k == 8) || (k == 301), 8'd10);
      if (k == 9) begin
        check("isi_7", isi0, 7);
        check("isi_7_valid", isi_valid0, 1);
        check("isi_7_ovf", isi_ovf0, 0);
      end
      if (k == 302) begin
        check("isi_sat", isi0, 255);
        check("isi_sat_ovf", isi_ovf0, 1);
      end
    end

    // Toggling line: 5 edges per 10-cycle window; narrow instance saturates.
    do_reset(2);
    drive(1'b0, 1'b1, 1'b0, 8'd10);
    for (int k = 1; k <= 23; k++) begin
      drive(1'b0, 1'b1, (k % 2) == 1, 8'd10);
      if (k == 11) begin
        check("tog_rate0", rate0, 5);
        check("tog_sat0", rate_sat0, 0);
        check("tog_rate1", rate1, 3);
        check("tog_sat1", rate_sat1, 1);
      end
    end
    // Drop enable mid-window: no pulse, previous rate held.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 8'd10);
      check("drop_no_valid", rate_valid0, 0);
    end
    check("drop_rate_held", rate0, 5);
    drive(1'b0, 1'b1, 1'b0, 8'd10);
    for (int k = 1; k <= 11; k++) drive(1'b0, 1'b1, k == 1, 8'd10);
    check("reen_rate", rate0, 1);
    check("reen_valid", rate_valid0, 1);

    // Boundary ownership with 4-cycle windows.
    do_reset(2);
    drive(1'b0, 1'b1, 1'b0, 8'd4);
    for (int k = 1; k <= 14; k++) begin
      drive(1'b0, 1'b1, (k == 4) || (k == 9), 8'd4);
      if (k == 5) check("bnd_last_cycle", rate0, 1);
      if (k == 9) check("bnd_next_window", rate0, 0);
      if (k == 13) check("bnd_valid_cycle", rate0, 1);
    end

    // Window length 0 with toggling line.
    for (int k = 0; k < 12; k++) drive(1'b0, 1'b1, ~spike, 8'd0);

    // Randomized segments.
    en_r = 1'b1;
    sp_r = 1'b0;
    for (int seg = 0; seg < 40; seg++) begin
      mode = $urandom_range(0, 4);
      seg_len = $urandom_range(20, 120);
      per = $urandom_range(2, 9);
      en_r = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: wl_r = 8'd0;
        1: wl_r = 8'd1;
        2: wl_r = 8'($urandom_range(2, 6));
        default: wl_r = 8'($urandom_range(7, 40));
      endcase
      for (int i = 0; i < seg_len; i++) begin
        case (mode)
          0: sp_r = ($urandom_range(0, 99) < 30);
          1: sp_r = ~spike;
          2: sp_r = ($urandom_range(0, 99) < 95);
          3: sp_r = ($urandom_range(0, 199) == 0);
          default: sp_r = ((i % per) == 0);
        endcase
        if ($urandom_range(0, 99) < 2) en_r = ~en_r;
        if ($urandom_range(0, 99) < 5) wl_r = 8'($urandom_range(0, 30));
        drive($urandom_range(0, 499) == 0, en_r, sp_r, wl_r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
